// File: rtl/axil_reg_ctrl.sv
// axil_reg_ctrl: AXI-Lite slave that sequences host MMIO accesses into
// single-cycle register-file strobes. Exactly one transaction is in flight,
// writes take priority over reads, and out-of-range or misaligned addresses
// are answered with SLVERR.
// Build option: define AXIL_REG_CTRL_STRB_EN to forward wstrb to reg_wstrb and
// suppress reg_wen for an all-zero strobe. Left undefined, wstrb is ignored and
// every write is presented with reg_wstrb = 4'hF.
module axil_reg_ctrl #(
  parameter int NUM_REGS = 16,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          awvalid,
  output logic          awready,
  input  logic [31:0]   awaddr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic          bvalid,
  input  logic          bready,
  output logic [1:0]    bresp,
  input  logic          arvalid,
  output logic          arready,
  input  logic [31:0]   araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [1:0]    rresp,
  output logic [31:0]   rdata,
  output logic          reg_wen,
  output logic [IW-1:0] reg_waddr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_wstrb,
  output logic          reg_ren,
  output logic [IW-1:0] reg_raddr,
  input  logic [31:0]   reg_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP
  } state_t;

  localparam logic [31:0] ADDR_LIMIT  = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  state_t          state_reg;
  logic            aw_held_reg, w_held_reg;
  logic [31:0]     awaddr_reg, wdata_reg;
  logic            wr_err_reg, rd_ok_reg;
  logic            awready_reg, wready_reg;
  logic            bvalid_reg, rvalid_reg;
  logic [1:0]      bresp_reg, rresp_reg;
  logic [31:0]     rdata_reg;
  logic            reg_wen_reg, reg_ren_reg;
  logic [IW-1:0]   reg_waddr_reg, reg_raddr_reg;
  logic [31:0]     reg_wdata_reg;
  logic [3:0]      reg_wstrb_reg;

  // In range means inside the register window and word aligned.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a < ADDR_LIMIT) && (a[1:0] == 2'b00);
  endfunction

  // awready/wready are only ever high in IDLE, so a handshake implies IDLE.
  logic aw_hs, w_hs, ar_hs, wr_go;
  assign aw_hs = awvalid && awready_reg;
  assign w_hs  = wvalid && wready_reg;
  // Reads are offered only when no write half is held or being presented.
  assign arready = awready_reg && wready_reg && !awvalid && !wvalid && !reset;
  assign ar_hs   = arvalid && arready;
  assign wr_go   = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

  // Effective write fields: this cycle's handshake if any, else the held copy.
  logic [31:0] wr_addr_eff, wr_data_eff;
  logic        wr_ok_eff, wr_fire;
  logic [3:0]  wr_strb_out;
  assign wr_addr_eff = aw_hs ? awaddr : awaddr_reg;
  assign wr_data_eff = w_hs ? wdata : wdata_reg;
  assign wr_ok_eff   = addr_ok(wr_addr_eff);

`ifdef AXIL_REG_CTRL_STRB_EN
  logic [3:0] wstrb_reg;
  assign wr_strb_out = w_hs ? wstrb : wstrb_reg;
  assign wr_fire     = wr_ok_eff && (wr_strb_out != 4'h0);
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
  assign wr_strb_out  = 4'hF;
  assign wr_fire      = wr_ok_eff;
`endif

  // Transaction sequencer: channel capture, strobe generation and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      aw_held_reg   <= 1'b0;
      w_held_reg    <= 1'b0;
      awaddr_reg    <= '0;
      wdata_reg     <= '0;
      wr_err_reg    <= 1'b0;
      rd_ok_reg     <= 1'b0;
      awready_reg   <= 1'b0;
      wready_reg    <= 1'b0;
      bvalid_reg    <= 1'b0;
      rvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
      rresp_reg     <= RESP_OKAY;
      rdata_reg     <= '0;
      reg_wen_reg   <= 1'b0;
      reg_ren_reg   <= 1'b0;
      reg_waddr_reg <= '0;
      reg_raddr_reg <= '0;
      reg_wdata_reg <= '0;
      reg_wstrb_reg <= '0;
`ifdef AXIL_REG_CTRL_STRB_EN
      wstrb_reg     <= '0;
`endif
    end else begin
      // Strobes are single-cycle pulses.
      reg_wen_reg <= 1'b0;
      reg_ren_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (aw_hs) begin
            aw_held_reg <= 1'b1;
            awaddr_reg  <= awaddr;
          end
          if (w_hs) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= wdata;
`ifdef AXIL_REG_CTRL_STRB_EN
            wstrb_reg  <= wstrb;
`endif
          end
          if (wr_go) begin
            state_reg   <= WR_EXEC;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            wr_err_reg  <= !wr_ok_eff;
            reg_wen_reg <= wr_fire;
            if (wr_fire) begin
              reg_waddr_reg <= wr_addr_eff[IW+1:2];
              reg_wdata_reg <= wr_data_eff;
              reg_wstrb_reg <= wr_strb_out;
            end
          end else if (ar_hs) begin
            state_reg   <= RD_EXEC;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            rd_ok_reg   <= addr_ok(araddr);
            reg_ren_reg <= addr_ok(araddr);
            if (addr_ok(araddr)) begin
              reg_raddr_reg <= araddr[IW+1:2];
            end
          end else begin
            awready_reg <= !(aw_held_reg || aw_hs);
            wready_reg  <= !(w_held_reg || w_hs);
          end
        end
        WR_EXEC: begin
          aw_held_reg <= 1'b0;
          w_held_reg  <= 1'b0;
          bvalid_reg  <= 1'b1;
          bresp_reg   <= wr_err_reg ? RESP_SLVERR : RESP_OKAY;
          state_reg   <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        RD_EXEC: begin
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          // reg_rdata answers the strobe issued in RD_EXEC.
          rdata_reg  <= rd_ok_reg ? reg_rdata : 32'h0;
          rresp_reg  <= rd_ok_reg ? RESP_OKAY : RESP_SLVERR;
          rvalid_reg <= 1'b1;
          state_reg  <= RD_RESP;
        end
        RD_RESP: begin
          if (rready) begin
            rvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign awready   = awready_reg;
  assign wready    = wready_reg;
  assign bvalid    = bvalid_reg;
  assign bresp     = bresp_reg;
  assign rvalid    = rvalid_reg;
  assign rresp     = rresp_reg;
  assign rdata     = rdata_reg;
  assign reg_wen   = reg_wen_reg;
  assign reg_waddr = reg_waddr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_wstrb = reg_wstrb_reg;
  assign reg_ren   = reg_ren_reg;
  assign reg_raddr = reg_raddr_reg;

endmodule

// File: doc/axil_reg_ctrl.md
# axil_reg_ctrl

AXI-Lite slave controller that sequences host MMIO accesses into single-cycle register-file read/write strobes. It sits between the shell's AXI-Lite port and the core's register bank. It accepts write address and write data in any order and holds exactly one transaction in flight. Writes win over reads when both are presented, and out-of-range or misaligned addresses get an SLVERR response.

## Interface
Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256; register index = addr[log2(NUM_REGS)+1:2]

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  32  write byte address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  write byte strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  32  read byte address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rresp  out  2  read response: OKAY or SLVERR
- rdata  out  32  read data
- reg_wen  out  1  one-cycle register write strobe
- reg_waddr  out  log2(NUM_REGS)  register write index
- reg_wdata  out  32  register write data
- reg_wstrb  out  4  register byte enables
- reg_ren  out  1  one-cycle register read strobe
- reg_raddr  out  log2(NUM_REGS)  register read index
- reg_rdata  in  32  register read data; valid exactly one cycle after reg_ren

## Operation
- States: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE, write capture:
  - awready = !aw_held.
  - wready = !w_held.
  - Each channel is latched on its own handshake.
  - Go to WR_EXEC in the cycle after both are held; this includes both channels arriving in the same cycle.
- IDLE, read acceptance:
  - arready = !aw_held && !w_held && !awvalid && !wvalid. This is a combinational Mealy term; writes have priority.
  - An AR handshake latches araddr and moves to RD_EXEC.
- Address check: an address is in range iff addr < NUM_REGS*4 and addr[1:0] == 0.
- WR_EXEC (1 cycle):
  - In range: reg_wen=1 with the latched index, data and strobes.
  - Out of range: no strobe.
  - Clear held flags and go to WR_RESP.
- WR_RESP:
  - bvalid=1; bresp=OKAY if in range, else SLVERR.
  - On bready, go to IDLE.
- RD_EXEC (1 cycle): reg_ren=1 if in range, then go to RD_WAIT.
- RD_WAIT (1 cycle):
  - Capture rdata = reg_rdata if in range, else 32'h0.
  - Go to RD_RESP.
- RD_RESP:
  - rvalid=1; rdata and rresp are held stable.
  - On rready, go to IDLE.
- While a write is held but incomplete, arready stays 0; a pending AR waits.
- Only one transaction is outstanding; AW, W and AR are never accepted outside IDLE.

## Timing
- Reset values:
  - State=IDLE; held flags=0.
  - awready=wready=arready=0 during the reset cycle; awready and wready rise in the first cycle after reset deasserts.
  - bvalid=rvalid=0; bresp=rresp=2'b00; rdata=0.
  - reg_wen=reg_ren=0; reg_waddr, reg_wdata, reg_wstrb, reg_raddr all 0.
- Write latency, last of AW/W handshake at cycle T: reg_wen at T+1, bvalid at T+2.
- Read latency, AR handshake at T: reg_ren at T+1, rdata captured at end of T+2, rvalid at T+3.
- Minimum back-to-back spacing: next AW/W accepted the cycle after the B handshake; next AR accepted the cycle after the R handshake.
- bvalid and rvalid never drop before their handshake. Payloads are unchanged while valid && !ready.
- Reset asserted mid-transaction:
  - Abandons it the next edge; no strobe issues afterwards.
  - Drops any pending bvalid or rvalid.
- All outputs are registered except arready.

## Configuration
- AXIL_REG_CTRL_STRB_EN:
  - Defined: reg_wstrb = latched wstrb; a write with wstrb=4'h0 is still OKAY but reg_wen is suppressed.
  - Undefined: wstrb is ignored and reg_wstrb is driven 4'hF on every write.

## Test plan
- Write in order, AW then W two cycles later, awaddr=0x8, wdata=0xDEADBEEF: reg_wen one cycle with reg_waddr=2 and reg_wdata=0xDEADBEEF; then bvalid with bresp=00.
- W before AW, plus same-cycle AW+W to 0x3C with NUM_REGS=16: exactly one reg_wen per transaction; reg_waddr=15; bvalid two cycles after the last handshake.
- Read araddr=0x4 with reg_rdata=0x12345678 returned one cycle after reg_ren: rvalid at T+3 with rdata=0x12345678 and rresp=00. Hold rready=0 for 5 cycles: rdata stays stable.
- Out of range, awaddr=0x40 and araddr=0x6:
  - Write: no reg_wen; bresp=10.
  - Read: no reg_ren; rdata=0; rresp=10.
- Simultaneous awvalid+wvalid+arvalid in IDLE: write completes first; AR is accepted only after the B handshake; the read returns the freshly written value.
- Reset asserted in WR_RESP with bready=0: bvalid=0 the next cycle and state is IDLE. A following write behaves normally. With the macro defined, wstrb=4'h0 gives no reg_wen and bresp=00.
